// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor command sequencer.
//   - opcode_e  : 3-bit command opcodes carried in instruction[2:0]
//   - state_e   : sequencer FSM states
//   - FLAG_*    : bit positions inside the 4-bit status word returned to the HPS
//   - OPC_W / OPND_W / INSTR_W : instruction field widths
package coproc_pkg;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPND_W  = 26;
    localparam int unsigned INSTR_W = OPC_W + OPND_W;

    typedef enum logic [OPC_W-1:0] {
        OpNop   = 3'd0,
        OpLoad  = 3'd1,
        OpStore = 3'd2,
        OpAdd   = 3'd3,
        OpSub   = 3'd4,
        OpMul   = 3'd5,
        OpScale = 3'd6,
        OpRsvd  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned FLAGS_W   = 4;
    localparam int unsigned FLAG_OVF  = 0;
    localparam int unsigned FLAG_ERR  = 1;
    localparam int unsigned FLAG_DONE = 2;
    localparam int unsigned FLAG_BUSY = 3;

endpackage

// File: rtl/coproc_sequencer.sv
// Command sequencer between an HPS PIO interface and a coprocessor datapath.
// A rising edge on enable (while idle) latches one instruction, hands it to the
// coprocessor with a start/ready handshake, waits for the completion pulse (or a
// timeout) and reports the result and status back to the HPS.
//
// Ports:
//   clk_clk        in   1   system clock, rising edge
//   reset_reset_n  in   1   asynchronous active-low reset
//   instruction    in   29  [2:0] opcode, [28:3] operand
//   enable         in   1   issue strobe (level; command issued on its rising edge)
//   dataout        out  8   last result returned by the coprocessor
//   flags          out  4   [3] busy, [2] done, [1] error, [0] overflow
//   cop_opcode     out  3   opcode to coprocessor
//   cop_operand    out  26  operand to coprocessor
//   cop_start      out  1   command valid
//   cop_ready      in   1   coprocessor accepts command
//   cop_done       in   1   one-cycle completion pulse
//   cop_result     in   8   result, valid with cop_done
//   cop_ovf        in   1   overflow, valid with cop_done
module coproc_sequencer
    import coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                enable,
    output logic [7:0]          dataout,
    output logic [FLAGS_W-1:0]  flags,
    output logic [OPC_W-1:0]    cop_opcode,
    output logic [OPND_W-1:0]   cop_operand,
    output logic                cop_start,
    input  logic                cop_ready,
    input  logic                cop_done,
    input  logic [7:0]          cop_result,
    input  logic                cop_ovf
);

    localparam int unsigned      CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT);

    state_e          state_q, state_d;
    logic            enable_q;
    logic            armed_q;
    logic            err_q;
    logic            ovf_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    opcode_e         instr_opc;
    logic            rise;
    logic            latch;
    logic            capture;
    logic            timeout_hit;

    assign instr_opc = opcode_e'(instruction[OPC_W-1:0]);

    // enable_q is forced low by reset, so an enable held high through reset
    // would look like a fresh edge. armed_q only goes high once enable has
    // actually been seen low after reset, which suppresses that false edge.
    assign rise = enable & ~enable_q & armed_q;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    latch = 1'b1;
                    if (instr_opc == OpNop || instr_opc == OpRsvd) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cop_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Completion wins over a timeout landing in the same cycle.
                if (cop_done) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else if (cnt_inc == CntMax) begin
                    timeout_hit = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            enable_q    <= 1'b0;
            armed_q     <= 1'b0;
            cop_opcode  <= '0;
            cop_operand <= '0;
            cnt_q       <= '0;
            dataout     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            enable_q <= enable;
            armed_q  <= armed_q | ~enable;

            if (latch) begin
                cop_opcode  <= instruction[OPC_W-1:0];
                cop_operand <= instruction[INSTR_W-1:OPC_W];
                err_q       <= (instr_opc == OpRsvd);
                ovf_q       <= 1'b0;
            end

            // Count restarts from zero on every entry into WAIT.
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_inc;
            end

            if (capture) begin
                dataout <= cop_result;
                ovf_q   <= cop_ovf;
            end

            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign cop_start = (state_q == StIssue);

    always_comb begin
        flags            = '0;
        flags[FLAG_BUSY] = (state_q == StIssue) || (state_q == StWait);
        flags[FLAG_DONE] = (state_q == StDone);
        flags[FLAG_ERR]  = err_q;
        flags[FLAG_OVF]  = ovf_q;
    end

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed bench for coproc_sequencer. Stimulus pushes the expected coprocessor
// command and the expected completion status into queues; a monitor pops and
// compares on every start&ready transfer and on every rising edge of done.
module tb_coproc_sequencer;

    localparam int unsigned TO = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [28:0] instruction;
    logic        enable;
    logic [7:0]  dataout;
    logic [3:0]  flags;
    logic [2:0]  cop_opcode;
    logic [25:0] cop_operand;
    logic        cop_start;
    logic        cop_ready;
    logic        cop_done;
    logic [7:0]  cop_result;
    logic        cop_ovf;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    logic [28:0] exp_cmd[$];
    logic [11:0] exp_res[$];

    always #5 clk_clk = ~clk_clk;

    coproc_sequencer #(.TIMEOUT(TO)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .instruction   (instruction),
        .enable        (enable),
        .dataout       (dataout),
        .flags         (flags),
        .cop_opcode    (cop_opcode),
        .cop_operand   (cop_operand),
        .cop_start     (cop_start),
        .cop_ready     (cop_ready),
        .cop_done      (cop_done),
        .cop_result    (cop_result),
        .cop_ovf       (cop_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [2:0] opc, input logic [25:0] opnd);
        instruction = {opnd, opc};
        enable      = 1'b1;
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        logic [28:0] ec;
        logic [11:0] er;
        bit          done_seen;
        done_seen = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset_n) begin
                done_seen = 1'b0;
            end else begin
                if (cop_start && cop_ready) begin
                    n_xfer++;
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer_unexpected: got %h, expected no transfer",
                                 {cop_operand, cop_opcode});
                    end else begin
                        ec = exp_cmd.pop_front();
                        check("xfer_cmd", 32'({cop_operand, cop_opcode}), 32'(ec));
                    end
                end
                if (flags[2] && !done_seen) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got %h, expected no completion",
                                 {dataout, flags});
                    end else begin
                        er = exp_res.pop_front();
                        check("done_result", 32'({dataout, flags}), 32'(er));
                    end
                end
                done_seen = flags[2];
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        reset_reset_n = 1'b0;
        instruction   = '0;
        enable        = 1'b0;
        cop_ready     = 1'b0;
        cop_done      = 1'b0;
        cop_result    = '0;
        cop_ovf       = 1'b0;

        #2;
        check("rst_dataout", 32'(dataout), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_start", 32'(cop_start), 32'h0);
        check("rst_cmd", 32'({cop_operand, cop_opcode}), 32'h0);
        ticks(2);
        reset_reset_n = 1'b1;
        ticks(2);

        // ADD, ready immediately, done 5 cycles into WAIT
        cop_ready = 1'b1;
        exp_cmd.push_back({26'h0000123, 3'd3});
        exp_res.push_back({8'h5A, 4'b0100});
        issue(3'd3, 26'h0000123);
        tick();
        check("add_start_n1", 32'(cop_start), 32'h1);
        check("add_busy_issue", 32'(flags), 32'h8);
        tick();
        check("add_start_once", 32'(cop_start), 32'h0);
        check("add_busy_wait", 32'(flags), 32'h8);
        ticks(4);
        cop_done   = 1'b1;
        cop_result = 8'h5A;
        check("add_flags_at_done", 32'(flags), 32'h8);
        tick();
        cop_done = 1'b0;
        check("add_flags", 32'(flags), 32'h4);
        check("add_dataout", 32'(dataout), 32'h5A);
        ticks(3);
        check("add_done_held", 32'(flags), 32'h4);
        enable = 1'b0;
        tick();
        check("add_flags_idle", 32'(flags), 32'h0);
        check("add_dataout_keep", 32'(dataout), 32'h5A);

        // Backpressure 10 cycles, second edge during WAIT, overflow result
        cop_ready = 1'b0;
        exp_cmd.push_back({26'h2AAAAAA, 3'd5});
        exp_res.push_back({8'hC3, 4'b0101});
        issue(3'd5, 26'h2AAAAAA);
        tick();
        instruction = '0;
        for (int i = 0; i < 10; i++) begin
            check("bp_start", 32'(cop_start), 32'h1);
            check("bp_cmd", 32'({cop_operand, cop_opcode}), 32'({26'h2AAAAAA, 3'd5}));
            if (i != 9) tick();
        end
        cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        check("bp_start_drop", 32'(cop_start), 32'h0);
        enable = 1'b0;
        tick();
        instruction = {26'h0000099, 3'd2};
        enable      = 1'b1;
        ticks(2);
        check("bp_ignored_edge", 32'(cop_start), 32'h0);
        cop_done   = 1'b1;
        cop_result = 8'hC3;
        cop_ovf    = 1'b1;
        tick();
        cop_done = 1'b0;
        cop_ovf  = 1'b0;
        check("ovf_flags", 32'(flags), 32'h5);
        enable = 1'b0;
        tick();
        check("ovf_persist", 32'(flags), 32'h1);
        tick();
        check("no_queued_issue", 32'(cop_start), 32'h0);

        // Timeout after exactly TO wait cycles
        cop_ready = 1'b1;
        exp_cmd.push_back({26'h0000015, 3'd4});
        exp_res.push_back({8'hC3, 4'b0110});
        issue(3'd4, 26'h0000015);
        ticks(2);
        ticks(TO - 1);
        check("to_busy_last", 32'(flags), 32'h8);
        tick();
        check("to_flags", 32'(flags), 32'h6);
        check("to_dataout", 32'(dataout), 32'hC3);
        enable = 1'b0;
        tick();
        check("to_err_persist", 32'(flags), 32'h2);

        // Done on the very cycle the count reaches TO -> success
        exp_cmd.push_back({26'h0000016, 3'd1});
        exp_res.push_back({8'h3C, 4'b0100});
        issue(3'd1, 26'h0000016);
        ticks(2);
        ticks(TO - 1);
        cop_done   = 1'b1;
        cop_result = 8'h3C;
        tick();
        cop_done = 1'b0;
        check("to_edge_flags", 32'(flags), 32'h4);
        check("to_edge_dataout", 32'(dataout), 32'h3C);
        enable = 1'b0;
        tick();

        // Reserved opcode
        exp_res.push_back({8'h3C, 4'b0110});
        issue(3'd7, 26'h0000001);
        tick();
        check("rsvd_flags", 32'(flags), 32'h6);
        check("rsvd_start", 32'(cop_start), 32'h0);
        enable = 1'b0;
        tick();

        // NOP
        exp_res.push_back({8'h3C, 4'b0100});
        issue(3'd0, 26'h0000055);
        tick();
        check("nop_flags", 32'(flags), 32'h4);
        check("nop_dataout", 32'(dataout), 32'h3C);
        enable = 1'b0;
        tick();
        check("nop_idle", 32'(flags), 32'h0);

        // Reset while waiting, enable held high through and after reset
        exp_cmd.push_back({26'h0000007, 3'd1});
        issue(3'd1, 26'h0000007);
        ticks(4);
        check("rw_busy", 32'(flags), 32'h8);
        reset_reset_n = 1'b0;
        #1;
        check("rw_dataout", 32'(dataout), 32'h0);
        check("rw_flags", 32'(flags), 32'h0);
        check("rw_start", 32'(cop_start), 32'h0);
        check("rw_cmd", 32'({cop_operand, cop_opcode}), 32'h0);
        tick();
        reset_reset_n = 1'b1;
        tick();
        cop_done   = 1'b1;
        cop_result = 8'hEE;
        tick();
        cop_done = 1'b0;
        ticks(3);
        check("rw_no_result", 32'(dataout), 32'h0);
        check("rw_no_flags", 32'(flags), 32'h0);
        check("rw_no_issue", 32'(cop_start), 32'h0);

        // Fresh edge re-arms; all-ones operand
        enable = 1'b0;
        tick();
        exp_cmd.push_back({26'h3FFFFFF, 3'd6});
        exp_res.push_back({8'h81, 4'b0100});
        issue(3'd6, 26'h3FFFFFF);
        ticks(2);
        cop_done   = 1'b1;
        cop_result = 8'h81;
        tick();
        cop_done = 1'b0;
        check("rearm_dataout", 32'(dataout), 32'h81);
        enable = 1'b0;
        ticks(2);
        check("rearm_idle", 32'(flags), 32'h0);

        check("xfer_count", 32'(n_xfer), 32'd6);
        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check("res_queue_empty", 32'(exp_res.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coproc_sequencer.md
COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'hFFFF: the maximum number of cycles spent in WAIT before an error is declared.
REQ-002 SHALL have port clk_clk  in  1  the single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port instruction  in  29  command word from HPS PIO; [2:0] opcode, [28:3] operand.
REQ-005 SHALL have port enable  in  1  HPS PIO issue strobe; level, same clock domain.
REQ-006 SHALL have port dataout  out  8  last result returned to HPS.
REQ-007 SHALL have port flags  out  4  status to HPS; [3] busy, [2] done, [1] error, [0] overflow.
REQ-008 SHALL have port cop_opcode  out  3  opcode to coprocessor datapath.
REQ-009 SHALL have port cop_operand  out  26  operand to coprocessor.
REQ-010 SHALL have port cop_start  out  1  command valid.
REQ-011 SHALL have port cop_ready  in  1  coprocessor accepts command.
REQ-012 SHALL have port cop_done  in  1  one-cycle completion pulse.
REQ-013 SHALL have port cop_result  in  8  result, valid with cop_done.
REQ-014 SHALL have port cop_ovf  in  1  overflow indication, valid with cop_done.

Function
REQ-015 SHALL register enable once and detect a rising edge as enable & ~enable_q.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-017 In IDLE, on a rising edge of enable, SHALL latch instruction and clear flags[1:0] and flags[2].
REQ-017a After the latch in REQ-017, SHALL go to ISSUE next cycle for opcodes 1..6, to DONE directly for opcode 0 (NOP), and to DONE with error=1 for opcode 7.
REQ-018 In ISSUE, SHALL hold cop_start=1 with stable cop_opcode/cop_operand until cop_ready=1; the transfer occurs in the cycle start&ready, then go to WAIT.
REQ-019 In WAIT, SHALL count cycles from 0; on cop_done it SHALL load dataout<=cop_result and flags[0]<=cop_ovf, then go to DONE.
REQ-020 If the count reaches TIMEOUT without cop_done, SHALL set error=1, leave dataout unchanged, and go to DONE.
REQ-021 cop_done arriving in the same cycle the count hits TIMEOUT SHALL be treated as success, with no error.
REQ-022 In DONE, SHALL assert done=1 and hold it until enable is low.
REQ-022a When enable is low in DONE, SHALL return to IDLE with done=0; dataout, error and overflow SHALL persist until the next issue.
REQ-023 busy SHALL be 1 exactly while in ISSUE or WAIT.
REQ-024 Rising edges of enable outside IDLE SHALL be ignored (no queueing).
REQ-024a Holding enable high across DONE->IDLE SHALL NOT re-issue; a fresh rising edge is required.
REQ-025 cop_done seen outside WAIT SHALL be ignored.
REQ-026 Issue latency: first cop_start SHALL be at cycle N+1, where N is the cycle the edge is detected.
REQ-026a dataout/flags SHALL update 1 cycle after cop_done.
REQ-027 cop_start SHALL be 0 in every state except ISSUE.

Reset
REQ-028 On reset_reset_n=0, SHALL asynchronously force: state=IDLE, dataout=0, flags=0, cop_start=0, cop_opcode=0, cop_operand=0, timeout counter=0, enable_q=0.
REQ-029 Reset mid-operation SHALL abandon the command with no result written; after release, the block SHALL require a new enable rising edge.

Structure
REQ-030 A shared package coproc_pkg SHALL hold the opcode enum (NOP=0, LOAD=1, STORE=2, ADD=3, SUB=4, MUL=5, SCALE=6, RSVD=7), the state enum, the flag bit indices, and the instruction field widths (OPC_W=3, OPND_W=26).
REQ-031 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and saturating.
REQ-032 No sub-modules; a single module with one FSM process and one datapath register process.

Verification
REQ-033 ADD issue: instruction={26'h0000123,3'd3}, enable 0->1, cop_ready=1 immediately, cop_done after 5 cycles with result 8'h5A -> cop_start one cycle, busy=1 during run, dataout=8'h5A, flags=4'b0100 until enable low, then 4'b0000.
REQ-034 Backpressure: cop_ready held 0 for 10 cycles -> cop_start and cop_operand stable for all 10 cycles, single transfer.
REQ-035 Timeout with TIMEOUT=16 and no cop_done -> flags=4'b0110 after 16 WAIT cycles, dataout unchanged.
REQ-036 Opcode 7 -> no cop_start, flags=4'b0110 one cycle after the edge.
REQ-036a NOP -> flags=4'b0100, dataout unchanged.
REQ-037 Second enable edge during WAIT -> ignored, only one command is issued; overflow: cop_ovf=1 with done -> flags[0]=1.
REQ-038 reset_reset_n pulsed low in WAIT -> all outputs 0 immediately; a later cop_done is ignored; enable held high after reset -> no issue.
